// File: rtl/pe_state_memory_pkg.sv
// Shared widths and state typedefs for the PE state stores.
// Imported by the PE and the interconnect so both agree on word sizes.
package pe_state_memory_pkg;

  localparam int DEF_NODE_ADDR_W = 4;
  localparam int DEF_NODE_DATA_W = 32;
  localparam int DEF_EDGE_ADDR_W = 6;
  localparam int DEF_EDGE_DATA_W = 16;

  typedef logic [DEF_NODE_ADDR_W-1:0] node_addr_t;
  typedef logic [DEF_NODE_DATA_W-1:0] node_state_t;
  typedef logic [DEF_EDGE_ADDR_W-1:0] edge_addr_t;
  typedef logic [DEF_EDGE_DATA_W-1:0] edge_state_t;

endpackage

// File: rtl/pe_state_memory_state_ram.sv
// Register-array RAM, 2R2W or 1R1W, write-first, clearable.
// Port A wins when both write ports hit the same word.
module state_ram #(
  parameter int AW       = 4,
  parameter int DW       = 32,
  parameter bit TWO_PORT = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [AW-1:0] rdaddr_a_i,
  input  logic [AW-1:0] rdaddr_b_i,
  input  logic [AW-1:0] wraddr_a_i,
  input  logic [AW-1:0] wraddr_b_i,
  input  logic          wren_a_i,
  input  logic          wren_b_i,
  input  logic [DW-1:0] wrdata_a_i,
  input  logic [DW-1:0] wrdata_b_i,
  output logic [DW-1:0] q_a_o,
  output logic [DW-1:0] q_b_o
);

  localparam int DEPTH = 2**AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] q_a_d;
  logic [DW-1:0] q_a_q;
  logic [DW-1:0] q_b_d;
  logic [DW-1:0] q_b_q;
  logic          wen_b;

  assign wen_b = TWO_PORT && wren_b_i;

  // Forward in-flight writes; A is checked first so it wins.
  always_comb begin
    q_a_d = mem_q[rdaddr_a_i];
    if (wren_a_i && (wraddr_a_i == rdaddr_a_i)) begin
      q_a_d = wrdata_a_i;
    end else if (wen_b && (wraddr_b_i == rdaddr_a_i)) begin
      q_a_d = wrdata_b_i;
    end
  end

  always_comb begin
    q_b_d = '0;
    if (TWO_PORT) begin
      q_b_d = mem_q[rdaddr_b_i];
      if (wren_a_i && (wraddr_a_i == rdaddr_b_i)) begin
        q_b_d = wrdata_a_i;
      end else if (wen_b && (wraddr_b_i == rdaddr_b_i)) begin
        q_b_d = wrdata_b_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      q_a_q <= '0;
      q_b_q <= '0;
    end else begin
      if (wen_b) begin
        mem_q[wraddr_b_i] <= wrdata_b_i;
      end
      if (wren_a_i) begin
        mem_q[wraddr_a_i] <= wrdata_a_i;
      end
      q_a_q <= q_a_d;
      q_b_q <= q_b_d;
    end
  end

  assign q_a_o = q_a_q;
  assign q_b_o = q_b_q;

endmodule

// File: rtl/pe_state_memory.sv
// PE state memory: 2R2W node store plus independent 1R1W edge store.
// Both stores clear synchronously on rst.
module pe_state_memory
  import pe_state_memory_pkg::*;
#(
  parameter int NODE_ADDR_W = DEF_NODE_ADDR_W,
  parameter int NODE_DATA_W = DEF_NODE_DATA_W,
  parameter int EDGE_ADDR_W = DEF_EDGE_ADDR_W,
  parameter int EDGE_DATA_W = DEF_EDGE_DATA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NODE_ADDR_W-1:0] n_rdaddr_a,
  input  logic [NODE_ADDR_W-1:0] n_rdaddr_b,
  input  logic [NODE_ADDR_W-1:0] n_wraddr_a,
  input  logic [NODE_ADDR_W-1:0] n_wraddr_b,
  input  logic                   n_wren_a,
  input  logic                   n_wren_b,
  input  logic [NODE_DATA_W-1:0] n_wrdata_a,
  input  logic [NODE_DATA_W-1:0] n_wrdata_b,
  output logic [NODE_DATA_W-1:0] n_q_a,
  output logic [NODE_DATA_W-1:0] n_q_b,
  input  logic [EDGE_ADDR_W-1:0] e_rdaddr,
  input  logic [EDGE_ADDR_W-1:0] e_wraddr,
  input  logic                   e_wren,
  input  logic [EDGE_DATA_W-1:0] e_wrdata,
  output logic [EDGE_DATA_W-1:0] e_q
);

  logic [EDGE_DATA_W-1:0] e_q_b_unused;

  state_ram #(
    .AW       (NODE_ADDR_W),
    .DW       (NODE_DATA_W),
    .TWO_PORT (1'b1)
  ) u_node (
    .clk_i      (clk),
    .rst_i      (rst),
    .rdaddr_a_i (n_rdaddr_a),
    .rdaddr_b_i (n_rdaddr_b),
    .wraddr_a_i (n_wraddr_a),
    .wraddr_b_i (n_wraddr_b),
    .wren_a_i   (n_wren_a),
    .wren_b_i   (n_wren_b),
    .wrdata_a_i (n_wrdata_a),
    .wrdata_b_i (n_wrdata_b),
    .q_a_o      (n_q_a),
    .q_b_o      (n_q_b)
  );

  // Edge store uses port A only; port B is tied off.
  state_ram #(
    .AW       (EDGE_ADDR_W),
    .DW       (EDGE_DATA_W),
    .TWO_PORT (1'b0)
  ) u_edge (
    .clk_i      (clk),
    .rst_i      (rst),
    .rdaddr_a_i (e_rdaddr),
    .rdaddr_b_i ('0),
    .wraddr_a_i (e_wraddr),
    .wraddr_b_i ('0),
    .wren_a_i   (e_wren),
    .wren_b_i   (1'b0),
    .wrdata_a_i (e_wrdata),
    .wrdata_b_i ('0),
    .q_a_o      (e_q),
    .q_b_o      (e_q_b_unused)
  );

endmodule

// File: tb/tb_pe_state_memory.sv
// Randomised and directed bench for pe_state_memory.
// Reference model: plain arrays updated with the store's write rules.
module tb_pe_state_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  n_rdaddr_a, n_rdaddr_b, n_wraddr_a, n_wraddr_b;
  logic        n_wren_a, n_wren_b;
  logic [31:0] n_wrdata_a, n_wrdata_b, n_q_a, n_q_b;
  logic [5:0]  e_rdaddr, e_wraddr;
  logic        e_wren;
  logic [15:0] e_wrdata, e_q;

  logic [31:0] node_m [16];
  logic [15:0] edge_m [64];
  logic [15:0] snap   [64];
  logic [31:0] exp_na, exp_nb;
  logic [15:0] exp_e;
  int checks   = 0;
  int failures = 0;

  pe_state_memory dut (
    .clk        (clk),
    .rst        (rst),
    .n_rdaddr_a (n_rdaddr_a),
    .n_rdaddr_b (n_rdaddr_b),
    .n_wraddr_a (n_wraddr_a),
    .n_wraddr_b (n_wraddr_b),
    .n_wren_a   (n_wren_a),
    .n_wren_b   (n_wren_b),
    .n_wrdata_a (n_wrdata_a),
    .n_wrdata_b (n_wrdata_b),
    .n_q_a      (n_q_a),
    .n_q_b      (n_q_b),
    .e_rdaddr   (e_rdaddr),
    .e_wraddr   (e_wraddr),
    .e_wren     (e_wren),
    .e_wrdata   (e_wrdata),
    .e_q        (e_q)
  );

  always #5 clk = ~clk;

  task automatic idle();
    rst = 1'b0;
    n_wren_a = 1'b0; n_wren_b = 1'b0; e_wren = 1'b0;
    n_wraddr_a = '0; n_wraddr_b = '0; e_wraddr = '0;
    n_wrdata_a = '0; n_wrdata_b = '0; e_wrdata = '0;
  endtask

  // One clock: update model with this edge's writes, then expected reads.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      foreach (node_m[i]) node_m[i] = '0;
      foreach (edge_m[i]) edge_m[i] = '0;
      exp_na = '0; exp_nb = '0; exp_e = '0;
    end else begin
      if (e_wren) edge_m[e_wraddr] = e_wrdata;
      if (n_wren_b) node_m[n_wraddr_b] = n_wrdata_b;
      if (n_wren_a) node_m[n_wraddr_a] = n_wrdata_a;
      exp_na = node_m[n_rdaddr_a];
      exp_nb = node_m[n_rdaddr_b];
      exp_e  = edge_m[e_rdaddr];
    end
    #1;
  endtask

  task automatic test_reset();
    idle();
    n_rdaddr_a = 4'd3; n_rdaddr_b = 4'd0; e_rdaddr = 6'd5;
    rst = 1'b1;
    step();
    checks++;
    if (n_q_a !== 32'h0 || n_q_b !== 32'h0 || e_q !== 16'h0) begin
      failures++;
      $display("FAIL reset_q got %h/%h/%h want 0", n_q_a, n_q_b, e_q);
    end
    rst = 1'b0;
    n_wren_a = 1'b1; n_wraddr_a = 4'd3; n_wrdata_a = 32'h1234_5678;
    e_wren = 1'b1; e_wraddr = 6'd5; e_wrdata = 16'h00AB;
    step();
    checks++;
    if (n_q_a !== 32'h1234_5678 || e_q !== 16'h00AB) begin
      failures++;
      $display("FAIL pre_reset_wr got %h/%h want 12345678/00ab", n_q_a, e_q);
    end
    rst = 1'b1;
    n_wrdata_a = 32'hCAFE_0001; e_wrdata = 16'hBEEF;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (n_q_a !== 32'h0 || e_q !== 16'h0) begin
        failures++;
        $display("FAIL reset_hold got %h/%h want 0", n_q_a, e_q);
      end
    end
    idle();
    step();
    checks++;
    if (n_q_a !== 32'h0 || e_q !== 16'h0) begin
      failures++;
      $display("FAIL post_reset got %h/%h want 0/0", n_q_a, e_q);
    end
  endtask

  task automatic test_latency();
    idle();
    n_rdaddr_a = 4'd2; n_rdaddr_b = 4'd2;
    n_wren_a = 1'b1; n_wraddr_a = 4'd2; n_wrdata_a = 32'hDEAD_BEEF;
    step();
    idle();
    n_rdaddr_a = 4'd2; n_rdaddr_b = 4'd3;
    step();
    checks++;
    if (n_q_a !== 32'hDEAD_BEEF || n_q_b !== 32'h0) begin
      failures++;
      $display("FAIL latency got %h/%h want deadbeef/0", n_q_a, n_q_b);
    end
    n_rdaddr_a = 4'd3;
    #3;
    checks++;
    if (n_q_a !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL hold got %h want deadbeef", n_q_a);
    end
    step();
  endtask

  task automatic test_dual_write();
    idle();
    n_wren_a = 1'b1; n_wraddr_a = 4'd1; n_wrdata_a = 32'h11;
    n_wren_b = 1'b1; n_wraddr_b = 4'd7; n_wrdata_b = 32'h77;
    step();
    idle();
    n_rdaddr_a = 4'd1; n_rdaddr_b = 4'd7;
    step();
    checks++;
    if (n_q_a !== 32'h11 || n_q_b !== 32'h77) begin
      failures++;
      $display("FAIL dual_wr got %h/%h want 11/77", n_q_a, n_q_b);
    end
    n_wren_a = 1'b1; n_wraddr_a = 4'd4; n_wrdata_a = 32'hAA;
    n_wren_b = 1'b1; n_wraddr_b = 4'd4; n_wrdata_b = 32'hBB;
    n_rdaddr_a = 4'd4; n_rdaddr_b = 4'd4;
    step();
    checks++;
    if (n_q_a !== 32'hAA || n_q_b !== 32'hAA) begin
      failures++;
      $display("FAIL collide_fwd got %h/%h want aa/aa", n_q_a, n_q_b);
    end
    idle();
    step();
    checks++;
    if (n_q_a !== 32'hAA || n_q_b !== 32'hAA) begin
      failures++;
      $display("FAIL collide_mem got %h/%h want aa/aa", n_q_a, n_q_b);
    end
  endtask

  task automatic test_write_first();
    idle();
    e_wren = 1'b1; e_wraddr = 6'd9; e_rdaddr = 6'd9; e_wrdata = 16'h5A5A;
    n_wren_a = 1'b1; n_wraddr_a = 4'd6; n_wrdata_a = 32'h0600_0006;
    n_rdaddr_b = 4'd6;
    step();
    checks++;
    if (e_q !== 16'h5A5A) begin
      failures++;
      $display("FAIL wf_edge got %h want 5a5a", e_q);
    end
    checks++;
    if (n_q_b !== 32'h0600_0006) begin
      failures++;
      $display("FAIL wf_node_b got %h want 06000006", n_q_b);
    end
    idle();
    n_wren_b = 1'b1; n_wraddr_b = 4'd8; n_wrdata_b = 32'h0800_0008;
    n_rdaddr_a = 4'd8;
    step();
    checks++;
    if (n_q_a !== 32'h0800_0008) begin
      failures++;
      $display("FAIL wf_node_a got %h want 08000008", n_q_a);
    end
  endtask

  task automatic test_sweep();
    idle();
    e_wren = 1'b1;
    for (int i = 0; i < 64; i++) begin
      e_wraddr = 6'(i);
      e_wrdata = 16'(i) ^ 16'h003C;
      step();
    end
    idle();
    for (int i = 0; i < 64; i++) begin
      e_rdaddr = 6'(i);
      step();
      checks++;
      if (e_q !== (16'(i) ^ 16'h003C)) begin
        failures++;
        $display("FAIL sweep[%0d] got %h want %h", i, e_q,
                 16'(i) ^ 16'h003C);
      end
    end
  endtask

  task automatic test_isolation();
    idle();
    foreach (snap[i]) snap[i] = edge_m[i];
    n_wren_a = 1'b1; n_wren_b = 1'b1;
    n_wrdata_a = 32'hFFFF_FFFF; n_wrdata_b = 32'hFFFF_FFFF;
    for (int i = 0; i < 16; i += 2) begin
      n_wraddr_a = 4'(i);
      n_wraddr_b = 4'(i + 1);
      step();
    end
    idle();
    for (int i = 0; i < 64; i++) begin
      e_rdaddr = 6'(i);
      step();
      checks++;
      if (e_q !== snap[i]) begin
        failures++;
        $display("FAIL iso_edge[%0d] got %h want %h", i, e_q, snap[i]);
      end
    end
    n_rdaddr_a = 4'd15; n_rdaddr_b = 4'd0;
    step();
    checks++;
    if (n_q_a !== 32'hFFFF_FFFF || n_q_b !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL iso_node got %h/%h want ffffffff", n_q_a, n_q_b);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      rst = 1'b0;
      n_wren_a   = 1'($urandom_range(0, 1));
      n_wren_b   = 1'($urandom_range(0, 1));
      e_wren     = 1'($urandom_range(0, 1));
      n_wraddr_a = 4'($urandom_range(0, 5));
      n_wraddr_b = 4'($urandom_range(0, 5));
      n_rdaddr_a = 4'($urandom_range(0, 5));
      n_rdaddr_b = 4'($urandom);
      n_wrdata_a = $urandom;
      n_wrdata_b = $urandom;
      e_wraddr   = 6'($urandom_range(0, 7));
      e_rdaddr   = 6'($urandom_range(0, 7));
      e_wrdata   = 16'($urandom);
      step();
      checks++;
      if (n_q_a !== exp_na || n_q_b !== exp_nb || e_q !== exp_e) begin
        failures++;
        $display("FAIL rand[%0d] got %h/%h/%h want %h/%h/%h", c,
                 n_q_a, n_q_b, e_q, exp_na, exp_nb, exp_e);
      end
    end
  endtask

  task automatic test_mid_reset();
    idle();
    n_wren_a = 1'b1; n_wraddr_a = 4'd10; n_wrdata_a = 32'hA5A5_0010;
    e_wren = 1'b1; e_wraddr = 6'd40; e_wrdata = 16'h4040;
    step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      n_rdaddr_a = 4'(i);
      n_rdaddr_b = 4'(15 - i);
      e_rdaddr = 6'(i + 32);
      step();
      checks++;
      if (n_q_a !== 32'h0 || n_q_b !== 32'h0 || e_q !== 16'h0) begin
        failures++;
        $display("FAIL mid_reset[%0d] got %h/%h/%h want 0", i,
                 n_q_a, n_q_b, e_q);
      end
    end
    e_wren = 1'b1; e_wraddr = 6'd1; e_wrdata = 16'h0101; e_rdaddr = 6'd1;
    step();
    checks++;
    if (e_q !== 16'h0101) begin
      failures++;
      $display("FAIL after_reset_wr got %h want 0101", e_q);
    end
  endtask

  initial begin
    idle();
    n_rdaddr_a = '0; n_rdaddr_b = '0; e_rdaddr = '0;
    test_reset();
    test_latency();
    test_dual_write();
    test_write_first();
    test_sweep();
    test_isolation();
    test_random();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pe_state_memory.md
PE_STATE_MEMORY -- requirements
Module: pe_state_memory

Interface
REQ-001 Parameter NODE_ADDR_W, default 4: node address width; node depth = 2**NODE_ADDR_W.
REQ-002 Parameter NODE_DATA_W, default 32: node state word width.
REQ-003 Parameter EDGE_ADDR_W, default 6: edge address width; edge depth = 2**EDGE_ADDR_W.
REQ-004 Parameter EDGE_DATA_W, default 16: edge state word width.
REQ-005 clk  in  1  sole clock; all logic rising-edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 n_rdaddr_a, n_rdaddr_b  in  NODE_ADDR_W each  node read addresses, ports A/B.
REQ-008 n_wraddr_a, n_wraddr_b  in  NODE_ADDR_W each  node write addresses, ports A/B.
REQ-009 n_wren_a, n_wren_b  in  1 each  node write enables.
REQ-010 n_wrdata_a, n_wrdata_b  in  NODE_DATA_W each  node write data.
REQ-011 n_q_a, n_q_b  out  NODE_DATA_W each  node read data, registered.
REQ-012 e_rdaddr, e_wraddr  in  EDGE_ADDR_W each  edge read/write addresses.
REQ-013 e_wren  in  1  edge write enable.
REQ-014 e_wrdata  in  EDGE_DATA_W  edge write data.
REQ-015 e_q  out  EDGE_DATA_W  edge read data, registered.

Function
REQ-016 Node store SHALL be a 2-read/2-write array of 2**NODE_ADDR_W words; edge store a 1-read/1-write array of 2**EDGE_ADDR_W words; the two stores are fully independent.
REQ-017 Every read SHALL have latency exactly 1: address sampled at edge k, data valid on q after edge k, held until the next edge.
REQ-018 Reads SHALL be unconditional every cycle (no read enable); n_q_a and n_q_b may read the same address and both return the same word.
REQ-019 A write with wren=1 at edge k SHALL update the word at wraddr at edge k; wren=0 leaves contents unchanged.
REQ-020 Read-during-write, same address, same cycle: q SHALL return the NEW data being written (write-first), on all read ports, for both stores.
REQ-021 Both node write ports enabled to the same address in one cycle: port A SHALL win, both for stored value and for any write-first forwarding.
REQ-022 Node ports A and B to different addresses SHALL both commit in the same cycle.
REQ-023 Addresses SHALL use the full width; no out-of-range case exists and no wrap logic is needed.

Reset
REQ-024 While rst=1 at a rising edge: n_q_a, n_q_b and e_q SHALL be 0 after that edge, and every node and edge word SHALL be cleared to 0.
REQ-025 Writes asserted during a reset cycle SHALL be ignored.
REQ-026 In the first cycle after rst deasserts, reads SHALL return 0 for any unwritten address, and writes SHALL take effect.
REQ-027 Reset asserted mid-operation SHALL discard all prior contents with no partial state retained.

Structure
REQ-028 NODE_ADDR_W, NODE_DATA_W, EDGE_ADDR_W and EDGE_DATA_W defaults, plus node-address/node-state/edge-address/edge-state typedefs, SHALL live in the shared project package so the PE and the interconnect agree on widths.
REQ-029 One sub-module, state_ram, SHALL be parameterised by address width, data width and a two-port-enable flag; it is instantiated twice: node store in 2R2W mode, edge store with port B tied off.
REQ-030 Storage SHALL be a register array so that synchronous reset can clear contents; no vendor RAM primitive is used.

Verification
REQ-031 Reset: hold rst=1 for 2 cycles after writing node[3]=0x1234_5678 and edge[5]=0x00AB; release; read node[3] and edge[5] -> 0x0000_0000 and 0x0000.
REQ-032 Basic latency: write node A[2]=0xDEAD_BEEF; next cycle n_rdaddr_a=2 and n_rdaddr_b=3 -> one cycle later n_q_a=0xDEAD_BEEF, n_q_b=0.
REQ-033 Dual write: same cycle A writes [1]=0x11, B writes [7]=0x77 -> later reads return 0x11 and 0x77; then A and B both write [4] with 0xAA/0xBB -> reads of [4] return 0xAA.
REQ-034 Write-first: e_wraddr=e_rdaddr=9, e_wrdata=0x5A5A, e_wren=1 -> e_q=0x5A5A after that edge; same check for node port B reading an address written by port A.
REQ-035 Sweep: write every edge address i with data i XOR 0x3C, then read back all 64 addresses sequentially -> every e_q matches, one cycle behind its address.
REQ-036 Isolation: writes to node[0..15] with 0xFFFF_FFFF leave all edge words unchanged (read edge[0..63] -> prior values).
